// File: rtl/negator_pkg.sv
// Shared types for the serial negator: FSM state encoding and negation modes.
package negator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/neg_chunk.sv
// CHUNK-bit invert-then-increment slice, built on the NOR-based not gate.
module nor_not (
    input  logic a,
    output logic y
);
    assign y = ~(a | a);
endmodule

module neg_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic             carry_in,
    output logic [CHUNK-1:0] y,
    output logic             carry_out
);
    logic [CHUNK-1:0] inv;

    for (genvar i = 0; i < CHUNK; i++) begin : g_not
        nor_not u_not (
            .a(x[i]),
            .y(inv[i])
        );
    end

    assign {carry_out, y} = {1'b0, inv} + {{CHUNK{1'b0}}, carry_in};
endmodule

// File: rtl/serial_negator.sv
// Multi-cycle WIDTH-bit ones'/two's complement negator, CHUNK bits per cycle.
// Define SERIAL_NEGATOR_SAT_EN to saturate the overflowing two's-complement case.
module serial_negator
    import negator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] res_q;
    logic             mode_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic             c_out;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] res_fin;
    logic             ovf;
    logic             zero;

    assign x_chunk = x_q[int'(cnt)*CHUNK +: CHUNK];

    neg_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x(x_chunk),
        .carry_in(carry),
        .y(y_chunk),
        .carry_out(c_out)
    );

    // Flags are judged on the fully assembled result of the last chunk.
    always_comb begin
        res_nxt = res_q;
        res_nxt[int'(cnt)*CHUNK +: CHUNK] = y_chunk;
        ovf = (mode_q == MODE_TWOS) & x_q[WIDTH-1] & res_nxt[WIDTH-1];
`ifdef SERIAL_NEGATOR_SAT_EN
        res_fin = ovf ? {1'b0, {(WIDTH-1){1'b1}}} : res_nxt;
`else
        res_fin = res_nxt;
`endif
        zero = (res_fin == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
            x_q       <= '0;
            res_q     <= '0;
            mode_q    <= MODE_ONES;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= in_data;
                        mode_q   <= in_mode;
                        carry    <= in_mode;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    res_q <= res_nxt;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_data  <= res_fin;
                        out_ovf   <= ovf;
                        out_zero  <= zero;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_negator.sv
// Self-checking bench for serial_negator: 16/4 vector table with scoreboard,
// backpressure and mid-operation reset sequences, and an 8-bit CHUNK sweep.
module tb_serial_negator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_negator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ovf(out_ovf),
        .out_zero(out_zero)
    );

    // 8-bit sweep instances: CHUNK = 1, 2, 8
    logic       sw_valid;
    logic [7:0] sw_x;
    logic       sw_mode;
    logic [2:0] sw_in_ready;
    logic [2:0] sw_out_valid;
    logic [2:0] sw_ovf;
    logic [2:0] sw_zero;
    logic [7:0] sw_out [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        serial_negator #(
            .WIDTH(8),
            .CHUNK((g == 0) ? 1 : (g == 1) ? 2 : 8)
        ) u_sw (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(sw_valid),
            .in_ready(sw_in_ready[g]),
            .in_data(sw_x),
            .in_mode(sw_mode),
            .out_valid(sw_out_valid[g]),
            .out_ready(1'b1),
            .out_data(sw_out[g]),
            .out_ovf(sw_ovf[g]),
            .out_zero(sw_zero[g])
        );
    end

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        logic        zero;
        logic        lat;
        int          t;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic        mode;
        logic [15:0] y;
        logic        ovf;
        logic        zero;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input logic m,
                        input logic [15:0] y, input logic ovf,
                        input logic zero, input logic lat,
                        input logic push);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else if (push) begin
            sb.push_back('{y: y, ovf: ovf, zero: zero, lat: lat, t: cyc});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Scoreboard monitor: sampled just after the falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none",
                         out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.y);
                chk("out_ovf", out_ovf, e.ovf);
                chk("out_zero", out_zero, e.zero);
                if (e.lat) chk("latency", cyc - e.t, 5);
            end
        end
    end

    function automatic logic [9:0] ref8(input logic [7:0] x, input logic m);
        logic [7:0] y;
        logic       ovf;
        y   = ~x + {7'b0, m};
        ovf = m & x[7] & y[7];
`ifdef SERIAL_NEGATOR_SAT_EN
        if (ovf) y = 8'h7F;
`endif
        return {ovf, (y == 8'h00), y};
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[1] = '{16'h00F0, 1'b0, 16'hFF0F, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
`ifdef SERIAL_NEGATOR_SAT_EN
        vecs[3] = '{16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0};
`else
        vecs[3] = '{16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0};
`endif
        vecs[4] = '{16'h8000, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'hFFFF, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[7] = '{16'h1234, 1'b1, 16'hEDCC, 1'b0, 1'b0};
        vecs[8] = '{16'h7FFF, 1'b1, 16'h8001, 1'b0, 1'b0};
        vecs[9] = '{16'hC3A5, 1'b0, 16'h3C5A, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_x      = 8'h0;
        sw_mode   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_out_zero", out_zero, 0);

        foreach (vecs[i])
            send(vecs[i].x, vecs[i].mode, vecs[i].y, vecs[i].ovf,
                 vecs[i].zero, 1'b1, 1'b1);
        drain();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        send(16'h1234, 1'b1, 16'hEDCC, 1'b0, 1'b0, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_data  = 16'hAAAA;
            in_mode  = 1'b0;
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 16'hEDCC);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        drain();

        // Reset in the middle of BUSY discards the operation.
        send(16'h5555, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid2", out_valid, 0);
        send(16'h0002, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();

        // 8-bit sweep over CHUNK = 1, 2, 8.
        for (int it = 0; it < 12; it++) begin
            logic [7:0] x;
            logic       m;
            logic [9:0] r;
            int         lat [3];
            bit         seen [3];
            x = (it == 0) ? 8'h80 : (it == 1) ? 8'h00 : 8'($urandom);
            m = (it < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            r = ref8(x, m);
            for (int i = 0; i < 3; i++) begin
                seen[i] = 1'b0;
                lat[i]  = 0;
            end
            @(negedge clk);
            chk("sw_in_ready", sw_in_ready, 3'b111);
            sw_x     = x;
            sw_mode  = m;
            sw_valid = 1'b1;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                sw_valid = 1'b0;
                #1;
                for (int i = 0; i < 3; i++) begin
                    if (!seen[i] && sw_out_valid[i]) begin
                        seen[i] = 1'b1;
                        lat[i]  = k;
                        chk("sw_out_data", sw_out[i], r[7:0]);
                        chk("sw_out_zero", sw_zero[i], r[8]);
                        chk("sw_out_ovf", sw_ovf[i], r[9]);
                    end
                end
            end
            chk("sw_seen0", seen[0], 1);
            chk("sw_seen1", seen[1], 1);
            chk("sw_seen2", seen[2], 1);
            chk("sw_lat_c1", lat[0], 9);
            chk("sw_lat_c2", lat[1], 5);
            chk("sw_lat_c8", lat[2], 2);
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
